// File: rtl/gpa_fhdo_dac_slave.sv
// SPI responder for the DAC80504-style 24-bit frame: oversampled in clk, four DAC channels with SYNC/LDAC, SDO readback.
// CSn rise at pin -> vout change is 4 clk; SCLK half-period must be >= 4 clk (no backpressure, master paced).
module gpa_fhdo_dac_slave #(
    parameter bit          SAMPLE_ON_FALL = 1'b1,
    parameter logic [15:0] RESET_CODE     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_i,
    input  logic        csn_i,
    input  logic        sdi_i,
    input  logic        ldacn_i,
    output logic        sdo_o,
    output logic        sdo_oe_o,
    output logic [15:0] vout0_o,
    output logic [15:0] vout1_o,
    output logic [15:0] vout2_o,
    output logic [15:0] vout3_o,
    output logic [3:0]  update_o,
    output logic        frame_err_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sclk_s, csn_s, ldac_s;
    logic [1:0]  sdi_s;
    logic [4:0]  cnt;
    logic [23:0] shreg;
    logic        pend_vld;
    logic [23:0] pend_word;
    logic [3:0]  sync_reg;
    logic [15:0] dac_buf [4];
    logic [15:0] vout    [4];
    logic [15:0] buf_nxt [4];
    logic [15:0] vout_nxt[4];
    logic [3:0]  upd_nxt;

    // Stage [1] is the synchronised level, stage [2] the previous one for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 3'b000;
            csn_s  <= 3'b111;
            ldac_s <= 3'b111;
            sdi_s  <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk_i};
            csn_s  <= {csn_s[1:0], csn_i};
            ldac_s <= {ldac_s[1:0], ldacn_i};
            sdi_s  <= {sdi_s[0], sdi_i};
        end
    end

    logic sclk_rise, sclk_fall, csn_fall, csn_rise, ldac_fall;
    logic sample_edge, drive_edge;
    assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
    assign csn_fall    = ~csn_s[1] & csn_s[2];
    assign csn_rise    = csn_s[1] & ~csn_s[2];
    assign ldac_fall   = ~ldac_s[1] & ldac_s[2];
    assign sample_edge = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
    assign drive_edge  = SAMPLE_ON_FALL ? sclk_rise : sclk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csn_fall) state_nxt = SHIFT;
            SHIFT:   if (csn_rise) state_nxt = COMMIT;
            default: state_nxt = IDLE;
        endcase
    end

    logic start, shift_en, drive_en, commit;
    always_comb begin
        start    = 1'b0;
        shift_en = 1'b0;
        drive_en = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE:    start = csn_fall;
            SHIFT: begin
                shift_en = sample_edge;
                drive_en = drive_edge;
            end
            default: commit = 1'b1;
        endcase
    end

    logic        frame_ok, wr, rd, soft_ldac, ldac_evt;
    logic [3:0]  addr;
    logic [15:0] wdat, rd_data;
    logic [23:0] load_word;
    logic        unused_bits;
    assign frame_ok    = commit && (cnt == 5'd24);
    assign wr          = frame_ok && !shreg[23];
    assign rd          = frame_ok && shreg[23];
    assign addr        = shreg[19:16];
    assign wdat        = shreg[15:0];
    assign soft_ldac   = wr && (addr == 4'h5) && wdat[4];
    assign ldac_evt    = ldac_fall || soft_ldac;
    assign load_word   = pend_vld ? pend_word : 24'h0;
    assign unused_bits = ^shreg[22:20];

    always_comb begin
        rd_data = 16'h0000;
        case (addr)
            4'h2:    rd_data = {12'h000, sync_reg};
            4'h8:    rd_data = dac_buf[0];
            4'h9:    rd_data = dac_buf[1];
            4'hA:    rd_data = dac_buf[2];
            4'hB:    rd_data = dac_buf[3];
            default: rd_data = 16'h0000;
        endcase
    end

    // A write in the same cycle as an LDAC event lands in the buffer first, so LDAC moves the new code.
    always_comb begin
        upd_nxt = 4'h0;
        for (int i = 0; i < 4; i++) begin
            buf_nxt[i]  = dac_buf[i];
            vout_nxt[i] = vout[i];
            if (wr && (addr == 4'(8 + i))) begin
                buf_nxt[i] = wdat;
                if (!sync_reg[i]) begin
                    vout_nxt[i] = wdat;
                    upd_nxt[i]  = 1'b1;
                end
            end
            if (ldac_evt && sync_reg[i]) begin
                vout_nxt[i] = buf_nxt[i];
                upd_nxt[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 5'd0;
            shreg       <= 24'h0;
            sdo_o       <= 1'b0;
            pend_vld    <= 1'b0;
            pend_word   <= 24'h0;
            sync_reg    <= 4'h0;
            update_o    <= 4'h0;
            frame_err_o <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dac_buf[i] <= RESET_CODE;
                vout[i]    <= RESET_CODE;
            end
        end else begin
            if (start) begin
                cnt      <= 5'd0;
                shreg    <= load_word;
                sdo_o    <= load_word[23];
                pend_vld <= 1'b0;
            end else if (shift_en) begin
                shreg <= {shreg[22:0], sdi_s[1]};
                cnt   <= (cnt == 5'd25) ? 5'd25 : cnt + 5'd1;
            end else if (drive_en) begin
                sdo_o <= shreg[23];
            end else if (state != SHIFT) begin
                sdo_o <= 1'b0;
            end
            if (commit) begin
                pend_vld  <= rd;
                pend_word <= {1'b1, 3'b000, addr, rd_data};
            end
            if (wr && (addr == 4'h2)) sync_reg <= wdat[3:0];
            for (int i = 0; i < 4; i++) begin
                dac_buf[i] <= buf_nxt[i];
                vout[i]    <= vout_nxt[i];
            end
            update_o    <= upd_nxt;
            frame_err_o <= commit && (cnt != 5'd24);
        end
    end

    assign sdo_oe_o = (state == SHIFT);
    assign vout0_o  = vout[0];
    assign vout1_o  = vout[1];
    assign vout2_o  = vout[2];
    assign vout3_o  = vout[3];
endmodule
